// File: rtl/mm_seq_ctrl.sv
// mm_seq_ctrl
// Job sequencer for the 4x4 matrix-multiply datapath. A start pulse walks the
// FSM through weight load, activation feed, drain and result write, then a
// one-cycle done. Every output is registered, so outputs show the state one
// cycle after the FSM enters it.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start_i; base addresses captured on launch
// S_LOAD_W | N beats: inst=01, read weights at w_base+2k
// S_FEED_X | N beats: inst=10, read activations at x_base+2k
// S_DRAIN  | DRAIN_CYC cycles: inst=10, no reads, array still clocked
// S_WRITE  | N beats: inst=00, write results at o_base+4k
// S_DONE   | one cycle: done pulse, then back to S_IDLE
//
// Ports
//   clk_i       sole clock, rising edge
//   rst_i       synchronous active-high reset
//   start_i     job launch, sampled only in S_IDLE
//   stall_i     freeze request, no effect in S_IDLE
//   w_base_i    weight base address
//   x_base_i    activation base address
//   o_base_i    result base address
//   busy_o      high from first LOAD_W cycle through DONE
//   done_o      one-cycle completion pulse
//   inst_o      array instruction (00 idle, 01 load weight, 10 compute)
//   array_en_o  systolic array clock-enable
//   rd_en_o     input-buffer read strobe
//   rd_addr_o   input-buffer read address
//   wr_en_o     output-buffer write strobe
//   wr_addr_o   output-buffer write address
module mm_seq_ctrl #(
  parameter int N         = 4,
  parameter int ADDR_W    = 8,
  parameter int DRAIN_CYC = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic [ADDR_W-1:0] w_base_i,
  input  logic [ADDR_W-1:0] x_base_i,
  input  logic [ADDR_W-1:0] o_base_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        inst_o,
  output logic              array_en_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o
);

  localparam int MAX_LEN = (N > DRAIN_CYC) ? N : DRAIN_CYC;
  localparam int CNT_W   = $clog2(MAX_LEN) + 1;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LDW  = 2'b01;
  localparam logic [1:0] INST_CMP  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_FEED_X, S_DRAIN, S_WRITE, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   w_q, w_d, x_q, x_d, o_q, o_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [1:0]          inst_q, inst_d;
  logic                array_en_q, array_en_d;
  logic                rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;

  logic                frozen;
  logic                last_beat, last_drain;
  logic [ADDR_W-1:0]   rd_off, wr_off;

  assign frozen     = stall_i && (state_q != S_IDLE);
  assign last_beat  = (cnt_q == CNT_W'(N - 1));
  assign last_drain = (cnt_q == CNT_W'(DRAIN_CYC - 1));
  assign rd_off     = ADDR_W'(cnt_q) << 1;
  assign wr_off     = ADDR_W'(cnt_q) << 2;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    w_d        = w_q;
    x_d        = x_q;
    o_d        = o_q;
    busy_d     = (state_q != S_IDLE);
    done_d     = 1'b0;
    inst_d     = INST_IDLE;
    array_en_d = 1'b0;
    rd_en_d    = 1'b0;
    wr_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;

    if (frozen) begin
      // Everything holds; only the strobes drop so no beat is lost.
      inst_d = inst_q;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d = S_LOAD_W;
            cnt_d   = '0;
            w_d     = w_base_i;
            x_d     = x_base_i;
            o_d     = o_base_i;
          end
        end
        S_LOAD_W: begin
          inst_d     = INST_LDW;
          array_en_d = 1'b1;
          rd_en_d    = 1'b1;
          rd_addr_d  = w_q + rd_off;
          if (last_beat) begin
            state_d = S_FEED_X;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_FEED_X: begin
          inst_d     = INST_CMP;
          array_en_d = 1'b1;
          rd_en_d    = 1'b1;
          rd_addr_d  = x_q + rd_off;
          if (last_beat) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DRAIN: begin
          inst_d     = INST_CMP;
          array_en_d = 1'b1;
          if (last_drain) begin
            state_d = S_WRITE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WRITE: begin
          array_en_d = 1'b1;
          wr_en_d    = 1'b1;
          wr_addr_d  = o_q + wr_off;
          if (last_beat) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      w_q        <= '0;
      x_q        <= '0;
      o_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      inst_q     <= INST_IDLE;
      array_en_q <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      w_q        <= w_d;
      x_q        <= x_d;
      o_q        <= o_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      inst_q     <= inst_d;
      array_en_q <= array_en_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign inst_o     = inst_q;
  assign array_en_o = array_en_q;
  assign rd_en_o    = rd_en_q;
  assign rd_addr_o  = rd_addr_q;
  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = wr_addr_q;

endmodule
